// File: rtl/kme_ib_framer_pkg.sv
// Shared types and constants for the kme_ib_framer inbound TLV framer.
// AXI-S widths fall back to local defaults when the build does not supply them.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 8
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif

package kme_ib_framer_pkg;
  localparam int DW = `AXI_S_DP_DWIDTH;
  localparam int SW = `AXI_S_TSTRB_WIDTH;
  localparam int UW = `AXI_S_USER_WIDTH;
  localparam int IW = `AXI_S_TID_WIDTH;

  localparam int SOT_BIT       = 0;
  localparam int EOT_BIT       = 1;
  localparam logic [7:0] MEGA_TYPE_MIN = 8'd21;
  localparam logic [7:0] GUID_TYPE     = 8'd10;
  localparam int GUID_FLAG_BIT = 4;

  typedef enum logic [1:0] {IDLE, OTHER, MEGA, GUID} ib_state_e;

  typedef struct packed {
    logic          tlast;
    logic [IW-1:0] tid;
    logic [UW-1:0] tuser;
    logic [SW-1:0] tstrb;
    logic [DW-1:0] tdata;
  } ib_word_t;

  function automatic ib_state_e decode_type(input logic [7:0] t);
    if (t >= MEGA_TYPE_MIN) return MEGA;
    if (t == GUID_TYPE)     return GUID;
    return OTHER;
  endfunction
endpackage

// File: rtl/kme_axis_skid.sv
// Two-entry AXI-S skid buffer: output register plus one overflow entry, registered ready.
module kme_axis_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         in_fire;

  assign in_fire = in_valid & in_ready;

  // in_ready tracks !skid_vld, so a word never arrives while the overflow entry is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      in_ready  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
      skid_vld <= 1'b0;
      in_ready <= 1'b1;
    end else if (in_fire) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= !skid_vld;
    end
  end
endmodule

// File: rtl/kme_ib_framer.sv
// Inbound TLV framer: passes AXI-S words through a skid buffer and marks tlast per TLV type.
// Optional statistics (frame_cnt, proto_err) are built only with KME_IB_FRAMER_STATS_EN.
module kme_ib_framer
  import kme_ib_framer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  input  logic [`AXI_S_DP_DWIDTH-1:0]   in_tdata,
  input  logic [`AXI_S_TSTRB_WIDTH-1:0] in_tstrb,
  input  logic [`AXI_S_USER_WIDTH-1:0]  in_tuser,
  input  logic [`AXI_S_TID_WIDTH-1:0]   in_tid,
  output logic                          kme_ib_tvalid,
  input  logic                          kme_ib_tready,
  output logic [`AXI_S_DP_DWIDTH-1:0]   kme_ib_tdata,
  output logic [`AXI_S_TSTRB_WIDTH-1:0] kme_ib_tstrb,
  output logic [`AXI_S_USER_WIDTH-1:0]  kme_ib_tuser,
  output logic [`AXI_S_TID_WIDTH-1:0]   kme_ib_tid,
  output logic                          kme_ib_tlast
`ifdef KME_IB_FRAMER_STATS_EN
  ,
  output logic [31:0]                   frame_cnt,
  output logic                          proto_err
`endif
);
  ib_state_e state, state_d, start_st;
  logic [1:0] wcnt, wcnt_d;
  logic       have_guid, hg_d, tlast_d;
  logic       in_fire, sot, eot;
  ib_word_t   in_word, out_word;

  assign in_fire  = in_tvalid & in_tready;
  assign sot      = in_tuser[SOT_BIT];
  assign eot      = in_tuser[EOT_BIT];
  assign start_st = decode_type(in_tdata[7:0]);

  // An SoT always opens a new TLV, abandoning whatever was open; SoT+EoT closes it immediately.
  always_comb begin
    tlast_d = 1'b0;
    state_d = state;
    wcnt_d  = wcnt;
    hg_d    = have_guid;
    if (sot) begin
      state_d = start_st;
      wcnt_d  = 2'd1;
      hg_d    = 1'b0;
      if (eot) begin
        tlast_d = (start_st == MEGA) || (start_st == GUID);
        state_d = IDLE;
      end
    end else begin
      unique case (state)
        IDLE:  state_d = IDLE;
        OTHER: if (eot) state_d = IDLE;
        GUID:  if (eot) begin
                 tlast_d = 1'b1;
                 state_d = IDLE;
               end
        MEGA:  if (eot) begin
                 tlast_d = !have_guid;
                 state_d = IDLE;
               end else begin
                 if (wcnt == 2'd1) hg_d = in_tdata[GUID_FLAG_BIT];
                 if (wcnt != 2'd3) wcnt_d = wcnt + 2'd1;
               end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= 2'd0;
      have_guid <= 1'b0;
    end else if (in_fire) begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      have_guid <= hg_d;
    end
  end

  always_comb begin
    in_word       = '0;
    in_word.tlast = tlast_d;
    in_word.tid   = in_tid;
    in_word.tuser = in_tuser;
    in_word.tstrb = in_tstrb;
    in_word.tdata = in_tdata;
  end

  kme_axis_skid #(.W($bits(ib_word_t))) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_tvalid),
    .in_ready  (in_tready),
    .in_data   (in_word),
    .out_valid (kme_ib_tvalid),
    .out_ready (kme_ib_tready),
    .out_data  (out_word)
  );

  assign kme_ib_tlast = out_word.tlast;
  assign kme_ib_tid   = out_word.tid;
  assign kme_ib_tuser = out_word.tuser;
  assign kme_ib_tstrb = out_word.tstrb;
  assign kme_ib_tdata = out_word.tdata;

`ifdef KME_IB_FRAMER_STATS_EN
  logic perr;
  assign perr = in_fire & (sot ? (state != IDLE) : (state == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 32'd0;
      proto_err <= 1'b0;
    end else begin
      if (kme_ib_tvalid && kme_ib_tready && kme_ib_tlast) frame_cnt <= frame_cnt + 32'd1;
      if (perr) proto_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_kme_ib_framer.sv
// Self-checking bench for kme_ib_framer: TLV-level reference model plus directed scenarios.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 8
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif

module tb_kme_ib_framer;
  localparam int DW = `AXI_S_DP_DWIDTH;
  localparam int SW = `AXI_S_TSTRB_WIDTH;
  localparam int UW = `AXI_S_USER_WIDTH;
  localparam int IW = `AXI_S_TID_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_tvalid, in_tready;
  logic [DW-1:0] in_tdata;
  logic [SW-1:0] in_tstrb;
  logic [UW-1:0] in_tuser;
  logic [IW-1:0] in_tid;
  logic          kme_ib_tvalid, kme_ib_tready, kme_ib_tlast;
  logic [DW-1:0] kme_ib_tdata;
  logic [SW-1:0] kme_ib_tstrb;
  logic [UW-1:0] kme_ib_tuser;
  logic [IW-1:0] kme_ib_tid;
`ifdef KME_IB_FRAMER_STATS_EN
  logic [31:0]   frame_cnt;
  logic          proto_err;
`endif

  always #5 clk = ~clk;

  kme_ib_framer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .in_tdata      (in_tdata),
    .in_tstrb      (in_tstrb),
    .in_tuser      (in_tuser),
    .in_tid        (in_tid),
    .kme_ib_tvalid (kme_ib_tvalid),
    .kme_ib_tready (kme_ib_tready),
    .kme_ib_tdata  (kme_ib_tdata),
    .kme_ib_tstrb  (kme_ib_tstrb),
    .kme_ib_tuser  (kme_ib_tuser),
    .kme_ib_tid    (kme_ib_tid),
    .kme_ib_tlast  (kme_ib_tlast)
`ifdef KME_IB_FRAMER_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .proto_err     (proto_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected output words, plus the bytes of the currently open TLV.
  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  tlv[$];
  logic [31:0] m_fcnt = 0;
  logic        m_perr = 1'b0;
  logic [31:0] tl_log = 0;
  int          tl_n = 0;
  int          out_cnt = 0;
  logic        prev_rst = 1'b0;
  logic        rnd_mode = 1'b0;

  // tlast is decided when a TLV closes, from its type byte and its second word (if one
  // exists before the EoT word).
  function automatic logic model_word(input logic [7:0] b, input logic sot, input logic eot);
    logic l;
    l = 1'b0;
    if (sot) begin
      if (tlv.size() != 0) m_perr = 1'b1;
      tlv.delete();
    end else if (tlv.size() == 0) begin
      m_perr = 1'b1;
      return 1'b0;
    end
    tlv.push_back(b);
    if (eot) begin
      if (tlv[0] >= 8'd21)      l = !(tlv.size() >= 3 && tlv[1][4]);
      else if (tlv[0] == 8'd10) l = 1'b1;
      tlv.delete();
    end
    return l;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_tvalid", kme_ib_tvalid, 0);
      chk("rst_in_tready", in_tready, 0);
      chk("rst_tlast", kme_ib_tlast, 0);
      chk("rst_tdata", kme_ib_tdata, 0);
      chk("rst_tuser", kme_ib_tuser, 0);
      q.delete();
      tlv.delete();
      m_fcnt = 0;
      m_perr = 1'b0;
`ifdef KME_IB_FRAMER_STATS_EN
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_proto_err", proto_err, 0);
`endif
    end else begin
      chk("tvalid", kme_ib_tvalid, q.size() != 0);
      if (prev_rst) chk("in_tready", in_tready, q.size() < 2);
      else          chk("in_tready_rel", in_tready, 0);
      if (q.size() != 0) begin
        chk("tdata", kme_ib_tdata, q[0].d);
        chk("tstrb", kme_ib_tstrb, q[0].s);
        chk("tuser", kme_ib_tuser, q[0].u);
        chk("tid",   kme_ib_tid,   q[0].i);
        chk("tlast", kme_ib_tlast, q[0].l);
      end
`ifdef KME_IB_FRAMER_STATS_EN
      chk("frame_cnt", frame_cnt, m_fcnt);
      chk("proto_err", proto_err, m_perr);
`endif
      // account for the handshakes that will happen on the coming rising edge
      if (kme_ib_tvalid && kme_ib_tready) begin
        out_cnt++;
        if (q.size() != 0) begin
          if (q[0].l) m_fcnt = m_fcnt + 1;
          tl_log = {tl_log[30:0], q[0].l};
          tl_n++;
          void'(q.pop_front());
        end
      end
      if (in_tvalid && in_tready) begin
        e.d = in_tdata; e.s = in_tstrb; e.u = in_tuser; e.i = in_tid;
        e.l = model_word(in_tdata[7:0], in_tuser[0], in_tuser[1]);
        q.push_back(e);
      end
    end
    prev_rst = rst_n;
  end

  initial begin
    kme_ib_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      kme_ib_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [7:0] b, input logic [UW-1:0] u);
    logic acc;
    acc       = 1'b0;
    in_tvalid = 1'b1;
    in_tdata  = {DW{1'b0}};
    in_tdata  = {$urandom, $urandom};
    in_tdata[7:0] = b;
    in_tstrb  = SW'($urandom);
    in_tid    = IW'($urandom);
    in_tuser  = u;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_tready) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_tvalid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !kme_ib_tvalid) begin done = 1'b1; break; end
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clr_log();
    tl_log = 0;
    tl_n   = 0;
  endtask

  task automatic chk_log(input string nm, input int n, input logic [31:0] v);
    chk({nm, "_count"}, tl_n, n);
    chk({nm, "_tlast"}, tl_log, v);
  endtask

  initial begin
    logic [31:0] base;
    int          oc;
    in_tvalid = 1'b0; in_tdata = '0; in_tstrb = '0; in_tuser = '0; in_tid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MEGA, word 2 without GUID flag: tlast only on the EoT word
    base = m_fcnt; clr_log();
    send(8'h15, 8'h01); send(8'h00, 8'h00); send(8'h00, 8'h00); send(8'h00, 8'h02);
    drain(); chk_log("mega_noguid", 4, 32'b0001);
    chk("mega_noguid_frames", m_fcnt - base, 1);

    // MEGA with GUID flag, then GUID TLV carries the tlast
    base = m_fcnt; clr_log();
    send(8'h15, 8'h01); send(8'h10, 8'h00); send(8'h00, 8'h02);
    send(8'h0A, 8'h01); send(8'h00, 8'h00); send(8'h00, 8'h02);
    drain(); chk_log("mega_guid", 6, 32'b000001);
    chk("mega_guid_frames", m_fcnt - base, 1);

    // word 2 that is also EoT is ignored for the GUID flag
    clr_log();
    send(8'h15, 8'h01); send(8'h10, 8'h02);
    drain(); chk_log("mega_w2_eot", 2, 32'b01);

    // word counter saturates: later words never relatch the flag
    clr_log();
    send(8'h16, 8'h01); send(8'h10, 8'h00);
    for (int k = 0; k < 5; k++) send(8'h00, 8'h00);
    send(8'h00, 8'h02);
    drain(); chk_log("mega_sat", 8, 32'b00000000);

    // OTHER type never gets tlast
    clr_log();
    send(8'h05, 8'h01); send(8'h00, 8'h00); send(8'h00, 8'h02);
    drain(); chk_log("other", 3, 32'b000);

    // SoT inside an open MEGA: abandon it, GUID closes with tlast
    clr_log();
    send(8'h15, 8'h01); send(8'h0A, 8'h01); send(8'h00, 8'h00); send(8'h00, 8'h02);
    drain(); chk_log("restart", 4, 32'b0001);
`ifdef KME_IB_FRAMER_STATS_EN
    chk("restart_proto_err", proto_err, 1);
`endif

    // single-word GUID TLV, then an EoT word proves the FSM is back in IDLE
    clr_log();
    send(8'h0A, 8'h03); send(8'h00, 8'h02);
    drain(); chk_log("single_guid", 2, 32'b10);

    // reset in the middle of a MEGA TLV
    send(8'h15, 8'h01); send(8'h10, 8'h00);
    drain();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clr_log();
    send(8'h00, 8'h00);
    drain(); chk_log("post_reset", 1, 32'b0);
`ifdef KME_IB_FRAMER_STATS_EN
    chk("post_reset_proto_err", proto_err, 1);
`endif

    // random stream under random backpressure
    rnd_mode = 1'b1;
    oc = out_cnt; clr_log();
    for (int k = 0; k < 200; k++) send(8'($urandom), UW'($urandom_range(0, 3)));
    drain();
    chk("rand_words_out", out_cnt - oc, 200);
    chk("rand_model_words", tl_n, 200);
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
